// File: rtl/ibpl_out_stretch.sv
// Output cardlet: per-channel pulse stretch/invert, LED hold, readback sync, sticky config error.
// Latency 1 cycle internal_out->diob_out, 2 cycles diob_in->internal_in; no backpressure.
module ibpl_out_stretch #(
    parameter int CHANNELS   = 6,
    parameter int CNT_W      = 16,
    parameter int LED_HOLD   = 2500000,
    parameter int ERR_FILTER = 4
) (
    input  logic                clk_sys,
    input  logic                rstn_sys,
    input  logic [CHANNELS-1:0] internal_out,
    input  logic [CHANNELS-1:0] output_enable,
    input  logic [CHANNELS-1:0] output_act,
    input  logic [CHANNELS-1:0] input_enable,
    input  logic [CHANNELS-1:0] stretch_en,
    input  logic [CHANNELS-1:0] invert,
    input  logic [CNT_W-1:0]    min_pulse,
    input  logic                error_clr,
    input  logic [CHANNELS-1:0] diob_in,
    output logic [CHANNELS-1:0] diob_out,
    output logic [CHANNELS-1:0] diob_dir,
    output logic [CHANNELS-1:0] internal_in,
    output logic [CHANNELS-1:0] diob_led1,
    output logic [CHANNELS-1:0] diob_led2,
    output logic                plugin_error
);

    localparam int LED_W = $clog2(LED_HOLD + 1);
    localparam int ERR_W = $clog2(ERR_FILTER + 1);

    logic [CHANNELS-1:0] in_prev_q, in_prev_d;
    logic [CHANNELS-1:0] diob_out_q, diob_out_d;
    logic [CHANNELS-1:0] diob_led1_q, diob_led1_d;
    logic [CHANNELS-1:0] diob_led2_q, diob_led2_d;
    logic [CHANNELS-1:0] sync1_q, sync1_d;
    logic [CHANNELS-1:0] sync2_q, sync2_d;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];
    logic [LED_W-1:0]    led_cnt_q [CHANNELS];
    logic [LED_W-1:0]    led_cnt_d [CHANNELS];
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
    logic                plugin_error_q, plugin_error_d;

    logic [CHANNELS-1:0] stretch_s;
    logic [CNT_W-1:0]    load_val;
    logic                err_cond;
    logic                err_set;

    // Loading min_pulse-1 keeps the total high time at min_pulse including the edge cycle.
    assign load_val = (min_pulse == '0) ? '0 : min_pulse - CNT_W'(1);

    always_comb begin
        in_prev_d   = internal_out;
        stretch_s   = internal_out;
        diob_out_d  = '0;
        diob_led1_d = '0;
        diob_led2_d = output_enable;
        sync1_d     = diob_in;
        sync2_d     = sync1_q;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i]     = '0;
            led_cnt_d[i] = '0;
            if (output_enable[i] && stretch_en[i]) begin
                stretch_s[i] = internal_out[i] | (cnt_q[i] != '0);
                if (internal_out[i] && !in_prev_q[i]) begin
                    cnt_d[i] = load_val;
                end else if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
            diob_out_d[i] = output_enable[i] & (stretch_s[i] ^ invert[i]);
            if (diob_out_d[i] != diob_out_q[i]) begin
                led_cnt_d[i] = LED_W'(LED_HOLD);
            end else if (led_cnt_q[i] != '0) begin
                led_cnt_d[i] = led_cnt_q[i] - LED_W'(1);
            end
            diob_led1_d[i] = output_act[i] | (led_cnt_q[i] != '0);
        end
    end

    // Set is judged on the registered count, so it wins over a coincident clear.
    always_comb begin
        err_cond  = |(input_enable & ~output_enable);
        err_set   = (err_cnt_q == ERR_W'(ERR_FILTER));
        err_cnt_d = '0;
        if (err_cond) begin
            err_cnt_d = err_set ? err_cnt_q : err_cnt_q + ERR_W'(1);
        end
        plugin_error_d = err_set | (plugin_error_q & ~(error_clr & ~err_cond));
    end

    always_ff @(posedge clk_sys or negedge rstn_sys) begin
        if (!rstn_sys) begin
            in_prev_q      <= '0;
            diob_out_q     <= '0;
            diob_led1_q    <= '0;
            diob_led2_q    <= '0;
            sync1_q        <= '0;
            sync2_q        <= '0;
            err_cnt_q      <= '0;
            plugin_error_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]     <= '0;
                led_cnt_q[i] <= '0;
            end
        end else begin
            in_prev_q      <= in_prev_d;
            diob_out_q     <= diob_out_d;
            diob_led1_q    <= diob_led1_d;
            diob_led2_q    <= diob_led2_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            err_cnt_q      <= err_cnt_d;
            plugin_error_q <= plugin_error_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]     <= cnt_d[i];
                led_cnt_q[i] <= led_cnt_d[i];
            end
        end
    end

    assign diob_dir     = '1;
    assign diob_out     = diob_out_q;
    assign internal_in  = sync2_q;
    assign diob_led1    = diob_led1_q;
    assign diob_led2    = diob_led2_q;
    assign plugin_error = plugin_error_q;

endmodule

// File: tb/tb_ibpl_out_stretch.sv
// Randomized and directed bench for ibpl_out_stretch against a cycle-level behavioural model.
module tb_ibpl_out_stretch;

    localparam int CH = 6;
    localparam int CW = 16;
    localparam int LH = 5;
    localparam int EF = 4;

    logic          core_clk = 1'b0;
    logic          rstn_sys = 1'b0;
    logic [CH-1:0] internal_out, output_enable, output_act, input_enable;
    logic [CH-1:0] stretch_en, invert, diob_in;
    logic [CW-1:0] min_pulse;
    logic          error_clr;
    logic [CH-1:0] diob_out, diob_dir, internal_in, diob_led1, diob_led2;
    logic          plugin_error;

    ibpl_out_stretch #(
        .CHANNELS(CH), .CNT_W(CW), .LED_HOLD(LH), .ERR_FILTER(EF)
    ) dut (
        .clk_sys(core_clk), .rstn_sys(rstn_sys),
        .internal_out(internal_out), .output_enable(output_enable),
        .output_act(output_act), .input_enable(input_enable),
        .stretch_en(stretch_en), .invert(invert), .min_pulse(min_pulse),
        .error_clr(error_clr), .diob_in(diob_in),
        .diob_out(diob_out), .diob_dir(diob_dir), .internal_in(internal_in),
        .diob_led1(diob_led1), .diob_led2(diob_led2), .plugin_error(plugin_error)
    );

    always #5 core_clk = ~core_clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vec_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Model: stretch windows as absolute expiry cycles, LED as time since last output change,
    // error as length of the current run of the bad condition.
    int            cyc;
    int            expire   [CH];
    int            last_chg [CH];
    int            run_len;
    logic [CH-1:0] m_prev_in, m_out, m_led1, m_led2, m_sync1, m_sync2;
    logic          m_err;

    task automatic model_reset();
        cyc = 0;
        run_len = 0;
        m_prev_in = '0; m_out = '0; m_led1 = '0; m_led2 = '0;
        m_sync1 = '0; m_sync2 = '0; m_err = 1'b0;
        for (int i = 0; i < CH; i++) begin
            expire[i]   = 0;
            last_chg[i] = -1000000;
        end
    endtask

    task automatic model_step();
        logic [CH-1:0] nout;
        bit            s;
        bit            cond;
        cyc++;
        nout = '0;
        for (int i = 0; i < CH; i++) begin
            s = internal_out[i];
            if (output_enable[i] && stretch_en[i]) begin
                s = internal_out[i] || (cyc < expire[i]);
                if (internal_out[i] && !m_prev_in[i]) expire[i] = cyc + int'(min_pulse);
            end else begin
                expire[i] = 0;
            end
            nout[i]   = output_enable[i] ? (s ^ invert[i]) : 1'b0;
            m_led1[i] = output_act[i] || (cyc - last_chg[i] <= LH);
            if (nout[i] != m_out[i]) last_chg[i] = cyc;
        end
        m_out     = nout;
        m_prev_in = internal_out;
        m_led2    = output_enable;
        m_sync2   = m_sync1;
        m_sync1   = diob_in;
        cond = |(input_enable & ~output_enable);
        if (run_len >= EF) m_err = 1'b1;
        else if (error_clr && !cond) m_err = 1'b0;
        run_len = cond ? run_len + 1 : 0;
    endtask

    task automatic check_all();
        chk("diob_dir", diob_dir, {CH{1'b1}});
        chk("diob_out", diob_out, m_out);
        chk("internal_in", internal_in, m_sync2);
        chk("diob_led1", diob_led1, m_led1);
        chk("diob_led2", diob_led2, m_led2);
        chk("plugin_error", plugin_error, m_err);
    endtask

    task automatic tick();
        @(posedge core_clk);
        if (rstn_sys) model_step();
        #1;
        check_all();
    endtask

    task automatic clear_inputs();
        internal_out = '0; output_enable = '0; output_act = '0; input_enable = '0;
        stretch_en = '0; invert = '0; diob_in = '0; min_pulse = '0; error_clr = 1'b0;
    endtask

    task automatic do_reset();
        rstn_sys = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge core_clk);
        #1;
        check_all();
        rstn_sys = 1'b1;
    endtask

    // Drives ch0 high for hi1, low for gap, high for hi2 and counts diob_out[0] high cycles.
    task automatic pulse_run(input int hi1, input int gap, input int hi2, output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            internal_out[0] = (k < hi1) || (k >= hi1 + gap && k < hi1 + gap + hi2);
            tick();
            n += int'(diob_out[0]);
        end
    endtask

    int n;

    initial begin
        clear_inputs();
        model_reset();
        #1;
        chk("rst_dir", diob_dir, 6'h3F);
        chk("rst_out", diob_out, 6'h00);
        chk("rst_err", plugin_error, 1'b0);
        @(posedge core_clk);
        #1;
        rstn_sys = 1'b1;
        tick();

        internal_out  = 6'h2A;
        output_enable = 6'h3F;
        tick();
        chk("pass_2a", diob_out, 6'h2A);

        clear_inputs();
        output_enable = 6'h01;
        stretch_en    = 6'h01;
        min_pulse     = 16'd10;
        repeat (3) tick();
        pulse_run(1, 0, 0, n);   chk("stretch_short", n, 10);
        pulse_run(15, 0, 0, n);  chk("stretch_long", n, 15);
        pulse_run(1, 5, 1, n);   chk("stretch_retrig", n, 16);
        min_pulse = 16'd1;
        pulse_run(3, 0, 0, n);   chk("stretch_mp1", n, 3);
        min_pulse = 16'd0;
        pulse_run(1, 0, 0, n);   chk("stretch_mp0", n, 1);

        clear_inputs();
        output_enable = 6'h01;
        invert        = 6'h01;
        tick();
        chk("invert_on", diob_out[0], 1'b1);
        invert          = 6'h00;
        stretch_en      = 6'h01;
        min_pulse       = 16'd10;
        internal_out[0] = 1'b1;
        tick();
        internal_out[0] = 1'b0;
        repeat (2) tick();
        output_enable = 6'h00;
        tick();
        chk("oe_drop", diob_out[0], 1'b0);
        output_enable = 6'h01;
        tick();
        chk("cnt_cleared", diob_out[0], 1'b0);

        clear_inputs();
        output_enable = 6'h02;
        repeat (10) tick();
        internal_out[1] = 1'b1;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            n += int'(diob_led1[1]);
        end
        chk("led_hold", n, LH);

        clear_inputs();
        repeat (8) tick();
        input_enable = 6'h04;
        repeat (3) tick();
        input_enable = 6'h00;
        repeat (2) tick();
        chk("err_3cyc", plugin_error, 1'b0);
        input_enable = 6'h04;
        repeat (5) tick();
        chk("err_4cyc", plugin_error, 1'b1);
        error_clr = 1'b1;
        tick();
        chk("err_clr_cond", plugin_error, 1'b1);
        error_clr    = 1'b0;
        input_enable = 6'h00;
        repeat (2) tick();
        chk("err_sticky", plugin_error, 1'b1);
        error_clr = 1'b1;
        tick();
        chk("err_cleared", plugin_error, 1'b0);
        error_clr = 1'b0;

        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 15) == 0) begin
                output_enable = $urandom_range(0, 3) == 0 ? CH'($urandom) : 6'h3F;
                stretch_en    = CH'($urandom);
                invert        = CH'($urandom);
                min_pulse     = CW'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 2) == 0) internal_out = CH'($urandom);
            input_enable = ($urandom_range(0, 3) == 0) ? CH'($urandom) : (output_enable & CH'($urandom));
            output_act   = ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0;
            diob_in      = CH'($urandom);
            error_clr    = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 399) == 0) do_reset();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
